uart_byte_tx: RTL and testbench

- Byte-level UART transmitter: the serialising end of the `txdata`/`send`/`txdone` byte interface used by the message buffer.
- Accepts one 8-bit byte per handshake and drives it onto the serial line as 8N1 (or 8N2) framing, LSB first.
- Returns a one-cycle `txdone` strobe when the frame, including its stop bits, has completed, so the buffer can present the next byte of a message.

---
 rtl/uart_byte_tx.sv | 126 ++++++++++++
 tb/tb_uart_byte_tx.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// Byte-level 8N1/8N2 UART transmitter: one byte per send handshake, LSB first.
// Ports: clk, reset (sync, active-high), txdata[7:0], send -> txdone, busy, tx.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txdata,
  input  logic       send,
  output logic       txdone,
  output logic       busy,
  output logic       tx
);

  localparam int CNT_WIDTH = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               r_state, w_state;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
  logic [2:0]           r_idx, w_idx;
  logic [7:0]           r_shift, w_shift;
  logic                 r_tx, w_tx;
  logic                 r_busy, w_busy;
  logic                 r_txdone, w_txdone;
  logic                 w_last;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_idx    = r_idx;
    w_shift  = r_shift;
    w_txdone = 1'b0;
    w_last   = (r_cnt == CNT_LAST);
    unique case (r_state)
      IDLE: begin
        if (send) begin
          w_state = START;
          w_shift = txdata;
          w_cnt   = '0;
          w_idx   = '0;
        end
      end
      START: begin
        if (w_last) begin
          w_state = DATA;
          w_cnt   = '0;
          w_idx   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_last) begin
          w_cnt = '0;
          if (r_idx == 3'd7) begin
            w_state = STOP;
            w_idx   = '0;
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        // r_idx counts stop bits here so 8N2 reuses the same counter.
        if (w_last) begin
          w_cnt = '0;
          if (r_idx == STOP_LAST) begin
            w_state  = IDLE;
            w_idx    = '0;
            w_txdone = 1'b1;
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase

    // Line level is derived from the next state so tx stays registered.
    unique case (w_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_shift[w_idx];
      default: w_tx = 1'b1;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_txdone <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_idx    <= w_idx;
      r_shift  <= w_shift;
      r_tx     <= w_tx;
      r_busy   <= w_busy;
      r_txdone <= w_txdone;
    end
  end

  assign tx     = r_tx;
  assign busy   = r_busy;
  assign txdone = r_txdone;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: CPB=4/1 stop and CPB=2/2 stop instances.
module tb_uart_byte_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] txdata1, txdata2;
  logic       send1, send2;
  logic       txdone1, busy1, tx1;
  logic       txdone2, busy2, tx2;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .txdata(txdata1), .send(send1),
    .txdone(txdone1), .busy(busy1), .tx(tx1)
  );

  uart_byte_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .txdata(txdata2), .send(send2),
    .txdone(txdone2), .busy(busy2), .tx(tx2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input int sel, input string tag,
                         input logic e_tx, input logic e_busy,
                         input logic e_done);
    chk({tag, " tx"},     sel == 0 ? tx1 : tx2,         e_tx);
    chk({tag, " busy"},   sel == 0 ? busy1 : busy2,     e_busy);
    chk({tag, " txdone"}, sel == 0 ? txdone1 : txdone2, e_done);
  endtask

  task automatic set_send(input int sel, input logic v);
    if (sel == 0) send1 = v;
    else send2 = v;
  endtask

  task automatic idle(input int sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_out(sel, $sformatf("%s idle%0d", tag, i), 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Caller sets send/txdata; the first tick here is the accept edge E.
  // Returns while in the txdone cycle.
  task automatic frame_check(input int sel, input logic [7:0] d,
                             input int cpb, input int nst,
                             input int drop_at, input int pulse_at,
                             input int chg_at, input logic [7:0] chg_d);
    logic [11:0] fr;
    int n;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    n       = (9 + nst) * cpb;
    tick();
    for (int c = 1; c <= n + 1; c++) begin
      if (c <= n)
        chk_out(sel, $sformatf("f%02h c%0d", d, c),
                fr[(c - 1) / cpb], 1'b1, 1'b0);
      else
        chk_out(sel, $sformatf("f%02h done", d), 1'b1, 1'b0, 1'b1);
      if (c == drop_at) set_send(sel, 1'b0);
      if (c == pulse_at) set_send(sel, 1'b1);
      if (c == pulse_at + 1) set_send(sel, 1'b0);
      if (c == chg_at) begin
        if (sel == 0) txdata1 = chg_d;
        else txdata2 = chg_d;
      end
      if (c <= n) tick();
    end
  endtask

  initial begin
    reset   = 1'b1;
    send1   = 1'b0;
    send2   = 1'b0;
    txdata1 = 8'h00;
    txdata2 = 8'h00;
    repeat (3) tick();
    chk_out(0, "rst", 1'b1, 1'b0, 1'b0);
    chk_out(1, "rstb", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    idle(0, 20, "post_rst");

    txdata1 = 8'hA5;
    send1   = 1'b1;
    frame_check(0, 8'hA5, 4, 1, 1, -1, -1, 8'h00);
    idle(0, 5, "a5");

    txdata1 = 8'h00;
    send1   = 1'b1;
    frame_check(0, 8'h00, 4, 1, -1, -1, 10, 8'hFF);
    frame_check(0, 8'hFF, 4, 1, 1, -1, -1, 8'h00);
    idle(0, 5, "b2b");

    txdata1 = 8'h5A;
    send1   = 1'b1;
    frame_check(0, 8'h5A, 4, 1, 1, 10, -1, 8'h00);
    idle(0, 8, "ignore");

    txdata1 = 8'hC3;
    send1   = 1'b1;
    tick();
    send1 = 1'b0;
    repeat (17) tick();
    chk_out(0, "bit3", 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    chk_out(0, "abort", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    idle(0, 45, "abort");

    txdata1 = 8'h3C;
    send1   = 1'b1;
    frame_check(0, 8'h3C, 4, 1, 1, -1, -1, 8'h00);
    idle(0, 3, "3c");

    txdata2 = 8'h81;
    send2   = 1'b1;
    frame_check(1, 8'h81, 2, 2, 1, -1, -1, 8'h00);
    idle(1, 3, "81");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
